// File: rtl/hpi_access_ctrl.sv
// hpi_access_ctrl
// Sequences single read/write transactions onto the CY7C67200 HPI bus via an
// I/O interface that registers both directions. Each transaction runs:
// chip-select setup, strobe pulse, two-cycle hold, then chip-select recovery.
// The OTG interrupt line is also synchronised here.
//
// Ports
//   Clk, Reset              clock, asynchronous active-high reset
//   i_req_valid/o_req_ready request handshake (ready only in IDLE)
//   i_req_write/addr/wdata  request: direction, HPI register select, write data
//   o_rsp_valid/o_rsp_rdata one-cycle completion pulse, last read data
//   o_hpi_address/data_out  to I/O interface, held from SETUP to end of HOLD
//   i_hpi_data_in           registered bus data from I/O interface
//   o_hpi_r/w/cs            active-low strobes
//   i_otg_int               asynchronous interrupt input
//   o_irq/o_irq_rise        synchronised interrupt level and rising-edge pulse
//
// state   | meaning
// IDLE    | bus released, waiting for a request
// SETUP   | CS low, address/data driven, no strobe
// STROBE  | RD_N or WR_N low for STROBE_CYCLES
// HOLD    | CS low, strobes high for 2 cycles; read data captured at the end
// RECOVER | CS high for RECOVERY_CYCLES; rsp_valid on the first cycle
module hpi_access_ctrl #(
    parameter int STROBE_CYCLES   = 4,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_rdata,
    output logic [1:0]  o_hpi_address,
    output logic [15:0] o_hpi_data_out,
    input  logic [15:0] i_hpi_data_in,
    output logic        o_hpi_r,
    output logic        o_hpi_w,
    output logic        o_hpi_cs,
    input  logic        i_otg_int,
    output logic        o_irq,
    output logic        o_irq_rise
);

    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
        $error("hpi_access_ctrl: STROBE_CYCLES must be in 1..15");
    end
    if (RECOVERY_CYCLES < 1 || RECOVERY_CYCLES > 15) begin : g_bad_recovery
        $error("hpi_access_ctrl: RECOVERY_CYCLES must be in 1..15");
    end

    // Counters are loaded with (length - 1) and the phase ends at zero.
    localparam logic [3:0] STROBE_LOAD  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVERY_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD    = 4'd1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_cnt_zero;
    logic        w_accept;
    logic        w_rsp_set;
    logic        w_rd_capture;

    logic        r_write;
    logic [1:0]  r_addr;
    logic [15:0] r_wdata;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_irq_prev;

    assign w_cnt_zero = (r_cnt == 4'd0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Strobes are decoded from the state register alone so that Reset drives
    // them inactive without waiting for a clock edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_rsp_set    = 1'b0;
        w_rd_capture = 1'b0;
        o_req_ready  = 1'b0;
        o_hpi_cs     = 1'b1;
        o_hpi_r      = 1'b1;
        o_hpi_w      = 1'b1;
        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = 4'd0;
                end
            end
            SETUP: begin
                o_hpi_cs    = 1'b0;
                w_state_nxt = STROBE;
                w_cnt_nxt   = STROBE_LOAD;
            end
            STROBE: begin
                o_hpi_cs = 1'b0;
                if (r_write) o_hpi_w = 1'b0;
                else         o_hpi_r = 1'b0;
                if (w_cnt_zero) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = HOLD_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            HOLD: begin
                o_hpi_cs = 1'b0;
                if (w_cnt_zero) begin
                    w_state_nxt  = RECOVER;
                    w_cnt_nxt    = RECOVER_LOAD;
                    w_rsp_set    = 1'b1;
                    w_rd_capture = ~r_write;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RECOVER: begin
                if (w_cnt_zero) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_write     <= 1'b0;
            r_addr      <= 2'd0;
            r_wdata     <= 16'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'd0;
        end else begin
            if (w_accept) begin
                r_write <= i_req_write;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
            end
            // Registered from the last HOLD cycle, so it lands on the first
            // RECOVER cycle together with the captured read data.
            r_rsp_valid <= w_rsp_set;
            if (w_rd_capture) r_rsp_rdata <= i_hpi_data_in;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_irq_prev <= 1'b0;
        end else begin
            r_sync1    <= i_otg_int;
            r_sync2    <= r_sync1;
            r_irq_prev <= r_sync2;
        end
    end

    assign o_hpi_address  = r_addr;
    assign o_hpi_data_out = r_wdata;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_irq          = r_sync2;
    assign o_irq_rise     = r_sync2 & ~r_irq_prev;

endmodule

// File: tb/tb_hpi_access_ctrl.sv
module tb_hpi_access_ctrl;

    localparam int S_CYC = 4;
    localparam int R_CYC = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        i_req_valid, i_req_write;
    logic [1:0]  i_req_addr;
    logic [15:0] i_req_wdata, i_hpi_data_in;
    logic        i_otg_int;

    logic        o_req_ready, o_rsp_valid, o_hpi_r, o_hpi_w, o_hpi_cs, o_irq, o_irq_rise;
    logic [15:0] o_rsp_rdata, o_hpi_data_out;
    logic [1:0]  o_hpi_address;

    logic        d2_req_ready, d2_rsp_valid, d2_hpi_r, d2_hpi_w, d2_hpi_cs, d2_irq, d2_irq_rise;
    logic [15:0] d2_rsp_rdata, d2_hpi_data_out;
    logic [1:0]  d2_hpi_address;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_rdata;

    always #5 Clk = ~Clk;

    hpi_access_ctrl u_dut (
        .Clk(Clk), .Reset(Reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
        .o_hpi_address(o_hpi_address), .o_hpi_data_out(o_hpi_data_out),
        .i_hpi_data_in(i_hpi_data_in),
        .o_hpi_r(o_hpi_r), .o_hpi_w(o_hpi_w), .o_hpi_cs(o_hpi_cs),
        .i_otg_int(i_otg_int), .o_irq(o_irq), .o_irq_rise(o_irq_rise)
    );

    hpi_access_ctrl #(.STROBE_CYCLES(1), .RECOVERY_CYCLES(15)) u_dut2 (
        .Clk(Clk), .Reset(Reset),
        .i_req_valid(i_req_valid), .o_req_ready(d2_req_ready),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(d2_rsp_valid), .o_rsp_rdata(d2_rsp_rdata),
        .o_hpi_address(d2_hpi_address), .o_hpi_data_out(d2_hpi_data_out),
        .i_hpi_data_in(i_hpi_data_in),
        .o_hpi_r(d2_hpi_r), .o_hpi_w(d2_hpi_w), .o_hpi_cs(d2_hpi_cs),
        .i_otg_int(i_otg_int), .o_irq(d2_irq), .o_irq_rise(d2_irq_rise)
    );

    // Called at a negedge with the DUT idle. Returns at the negedge where
    // o_req_ready is seen again; with hold=1 req_valid stays high so the next
    // call chains back-to-back.
    task automatic run_txn(input logic wr, input logic [1:0] a, input logic [15:0] wd,
                           input logic [15:0] rd, input bit hold);
        int k, cs_low, w_low, r_low, bad, unstable, rsp_n, rsp_k, rec;
        logic [15:0] rsp_d;
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL txn_start_ready got %b expected 1", o_req_ready);
        end
        i_req_valid = 1'b1; i_req_write = wr; i_req_addr = a; i_req_wdata = wd;
        i_hpi_data_in = 16'($urandom);
        @(negedge Clk);
        k = 1; cs_low = 0; w_low = 0; r_low = 0; bad = 0; unstable = 0;
        rsp_n = 0; rsp_k = 0; rec = 0; rsp_d = '0;
        while (o_req_ready !== 1'b1 && k <= 40) begin
            if (o_hpi_cs === 1'b0) cs_low++;
            if (o_hpi_w === 1'b0) w_low++;
            if (o_hpi_r === 1'b0) r_low++;
            if (o_hpi_cs === 1'b1) rec++;
            if ((o_hpi_r === 1'b0 && o_hpi_w === 1'b0) ||
                ((o_hpi_r === 1'b0 || o_hpi_w === 1'b0) && o_hpi_cs !== 1'b0)) bad++;
            if (o_hpi_cs === 1'b0 && (o_hpi_address !== a || o_hpi_data_out !== wd)) unstable++;
            if (o_rsp_valid === 1'b1) begin
                rsp_n++; rsp_k = k; rsp_d = o_rsp_rdata;
            end
            if (!wr && r_low == 1) i_hpi_data_in = rd;
            // Busy-time request inputs are noise and must be ignored.
            i_req_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
            i_req_write = 1'($urandom);
            i_req_addr  = 2'($urandom);
            i_req_wdata = 16'($urandom);
            @(negedge Clk);
            k++;
        end
        if (!hold) i_req_valid = 1'b0;
        if (!wr) model_rdata = rd;

        checks++;
        if (k - 1 != 1 + S_CYC + 2 + R_CYC) begin
            errors++; $display("FAIL latency got %0d expected %0d", k - 1, 1 + S_CYC + 2 + R_CYC);
        end
        checks++;
        if (cs_low != 1 + S_CYC + 2) begin
            errors++; $display("FAIL cs_low_cycles got %0d expected %0d", cs_low, 1 + S_CYC + 2);
        end
        checks++;
        if (w_low != (wr ? S_CYC : 0) || r_low != (wr ? 0 : S_CYC)) begin
            errors++; $display("FAIL strobe_len w=%0d r=%0d expected w=%0d r=%0d",
                               w_low, r_low, wr ? S_CYC : 0, wr ? 0 : S_CYC);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL strobe_legal got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (unstable != 0) begin
            errors++; $display("FAIL addr_data_stable got %0d bad cycles expected 0", unstable);
        end
        checks++;
        if (rec != R_CYC) begin
            errors++; $display("FAIL recover_gap got %0d expected %0d", rec, R_CYC);
        end
        checks++;
        if (rsp_n != 1 || rsp_k != 1 + S_CYC + 2 + 1) begin
            errors++; $display("FAIL rsp_pulse count %0d at cycle %0d expected 1 at %0d",
                               rsp_n, rsp_k, 1 + S_CYC + 2 + 1);
        end
        checks++;
        if (rsp_d !== model_rdata || o_rsp_rdata !== model_rdata) begin
            errors++; $display("FAIL rsp_rdata pulse %h after %h expected %h",
                               rsp_d, o_rsp_rdata, model_rdata);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (o_req_ready !== 1'b1 || o_hpi_cs !== 1'b1 || o_hpi_r !== 1'b1 || o_hpi_w !== 1'b1 ||
            o_hpi_address !== 2'd0 || o_hpi_data_out !== 16'd0 || o_rsp_valid !== 1'b0 ||
            o_rsp_rdata !== 16'd0 || o_irq !== 1'b0 || o_irq_rise !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rdy=%b cs=%b r=%b w=%b a=%h d=%h rv=%b rd=%h irq=%b rise=%b expected 1 1 1 1 0 0 0 0 0 0",
                     o_req_ready, o_hpi_cs, o_hpi_r, o_hpi_w, o_hpi_address, o_hpi_data_out,
                     o_rsp_valid, o_rsp_rdata, o_irq, o_irq_rise);
        end
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset got %b expected 1", o_req_ready);
        end
    endtask

    task automatic test_write_basic();
        run_txn(1'b1, 2'd2, 16'h1234, 16'h0000, 1'b0);
    endtask

    task automatic test_read_basic();
        run_txn(1'b0, 2'd3, 16'h5A5A, 16'hBEEF, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_txn((i % 2) == 0, 2'($urandom), 16'($urandom), 16'($urandom), i != 5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_txn(1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                    (i != 19) && ($urandom_range(0, 1) == 1));
    endtask

    task automatic test_reset_mid();
        int rv_n, cs_n;
        run_txn(1'b0, 2'd1, 16'h0, 16'hC0DE, 1'b0);
        i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 2'd1; i_req_wdata = 16'hFFFF;
        i_hpi_data_in = 16'hAAAA;
        @(negedge Clk); i_req_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (o_hpi_r !== 1'b0 || o_hpi_cs !== 1'b0) begin
            errors++; $display("FAIL mid_strobe_active r=%b cs=%b expected 0 0", o_hpi_r, o_hpi_cs);
        end
        #1 Reset = 1'b1;
        #1;
        checks++;
        if (o_hpi_cs !== 1'b1 || o_hpi_r !== 1'b1 || o_hpi_w !== 1'b1 || o_rsp_valid !== 1'b0 ||
            o_rsp_rdata !== 16'd0 || o_hpi_address !== 2'd0 || o_hpi_data_out !== 16'd0) begin
            errors++;
            $display("FAIL async_reset cs=%b r=%b w=%b rv=%b rd=%h a=%h d=%h expected 1 1 1 0 0000 0 0000",
                     o_hpi_cs, o_hpi_r, o_hpi_w, o_rsp_valid, o_rsp_rdata, o_hpi_address, o_hpi_data_out);
        end
        model_rdata = 16'd0;
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;
        rv_n = 0; cs_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                checks++;
                if (o_req_ready !== 1'b1) begin
                    errors++; $display("FAIL ready_post_reset got %b expected 1", o_req_ready);
                end
            end
            if (o_rsp_valid === 1'b1) rv_n++;
            if (o_hpi_cs === 1'b0) cs_n++;
        end
        checks++;
        if (rv_n != 0 || cs_n != 0 || o_rsp_rdata !== 16'd0) begin
            errors++; $display("FAIL aborted_txn rsp=%0d cs_low=%0d rdata=%h expected 0 0 0000",
                               rv_n, cs_n, o_rsp_rdata);
        end
    endtask

    task automatic test_short_strobe();
        int k, r_low, cs_low, rsp_n;
        logic [15:0] rsp_d, v;
        k = 0;
        while ((d2_req_ready !== 1'b1 || o_req_ready !== 1'b1) && k < 60) begin
            @(negedge Clk); k++;
        end
        v = 16'($urandom);
        i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 2'd0; i_req_wdata = 16'h0F0F;
        i_hpi_data_in = v;
        @(negedge Clk);
        i_req_valid = 1'b0;
        k = 1; r_low = 0; cs_low = 0; rsp_n = 0; rsp_d = '0;
        while (d2_req_ready !== 1'b1 && k <= 60) begin
            if (d2_hpi_r === 1'b0) r_low++;
            if (d2_hpi_cs === 1'b0) cs_low++;
            if (d2_rsp_valid === 1'b1) begin rsp_n++; rsp_d = d2_rsp_rdata; end
            @(negedge Clk); k++;
        end
        model_rdata = v;
        checks++;
        if (k - 1 != 19) begin
            errors++; $display("FAIL short_latency got %0d expected 19", k - 1);
        end
        checks++;
        if (r_low != 1 || cs_low != 4) begin
            errors++; $display("FAIL short_strobe r_low=%0d cs_low=%0d expected 1 4", r_low, cs_low);
        end
        checks++;
        if (rsp_n != 1 || rsp_d !== v) begin
            errors++; $display("FAIL short_rsp count=%0d data=%h expected 1 %h", rsp_n, rsp_d, v);
        end
        checks++;
        if (o_rsp_rdata !== model_rdata) begin
            errors++; $display("FAIL dut1_rdata got %h expected %h", o_rsp_rdata, model_rdata);
        end
    endtask

    task automatic test_irq();
        int k, rises;
        checks++;
        if (o_irq !== 1'b0 || o_irq_rise !== 1'b0) begin
            errors++; $display("FAIL irq_idle irq=%b rise=%b expected 0 0", o_irq, o_irq_rise);
        end
        @(posedge Clk); #3 i_otg_int = 1'b1;
        k = 0;
        while (o_irq !== 1'b1 && k < 10) begin
            @(posedge Clk); #1; k++;
        end
        checks++;
        if (k < 2 || k > 3) begin
            errors++; $display("FAIL irq_latency got %0d expected 2..3", k);
        end
        rises = (o_irq_rise === 1'b1) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            if (o_irq_rise === 1'b1) rises++;
        end
        checks++;
        if (rises != 1 || o_irq !== 1'b1) begin
            errors++; $display("FAIL irq_rise_once rises=%0d irq=%b expected 1 1", rises, o_irq);
        end
        i_otg_int = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        checks++;
        if (o_irq !== 1'b0) begin
            errors++; $display("FAIL irq_fall got %b expected 0", o_irq);
        end
        #2 i_otg_int = 1'b1;
        rises = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (o_irq_rise === 1'b1) rises++;
        end
        checks++;
        if (rises != 1) begin
            errors++; $display("FAIL irq_second_rise rises=%0d expected 1", rises);
        end
    endtask

    initial begin
        Reset = 1'b1;
        i_req_valid = 1'b0; i_req_write = 1'b0; i_req_addr = '0; i_req_wdata = '0;
        i_hpi_data_in = '0; i_otg_int = 1'b0;
        model_rdata = 16'd0;
        #12;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_short_strobe();
        test_irq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpi_access_ctrl.md
HPI_ACCESS_CTRL -- requirements
Module: hpi_access_ctrl

Interface
REQ-001 Parameter: STROBE_CYCLES, default 4, RD_N/WR_N low-pulse length in Clk cycles; legal range 1..15; other values SHALL be rejected at elaboration.
REQ-002 Parameter: RECOVERY_CYCLES, default 2, CS high idle time between transactions in Clk cycles; legal range 1..15; other values SHALL be rejected at elaboration.
REQ-003 Clk  in  1  system clock; all state SHALL change on posedge Clk.
REQ-004 Reset  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  transaction request.
REQ-006 req_ready  out  1  controller accepts a request this cycle.
REQ-007 req_write  in  1  1 = HPI write, 0 = HPI read.
REQ-008 req_addr  in  2  HPI register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS).
REQ-009 req_wdata  in  16  write data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse, for reads and writes.
REQ-011 rsp_rdata  out  16  read data, valid when rsp_valid pulses after a read.
REQ-012 hpi_address  out  2  to I/O interface address input.
REQ-013 hpi_data_out  out  16  to I/O interface write-data input.
REQ-014 hpi_data_in  in  16  registered bus data from I/O interface.
REQ-015 hpi_r, hpi_w, hpi_cs  out  1 each  active-low strobes to I/O interface.
REQ-016 otg_int  in  1  asynchronous interrupt from the OTG controller.
REQ-017 irq  out  1  synchronised otg_int level; irq_rise  out  1  one-cycle pulse on irq rising edge.

Function
REQ-018 FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER; one transaction in flight at most.
REQ-019 req_ready SHALL be 1 exactly when state = IDLE; accept on req_valid && req_ready; req_* SHALL be latched at acceptance and ignored afterwards.
REQ-020 IDLE: hpi_cs = hpi_r = hpi_w = 1; on accept -> SETUP.
REQ-021 SETUP (1 cycle): hpi_cs = 0, hpi_address and hpi_data_out = latched values, hpi_r = hpi_w = 1 -> STROBE.
REQ-022 STROBE (STROBE_CYCLES cycles): hpi_cs = 0; hpi_w = 0 if write else hpi_r = 0; the other strobe = 1 -> HOLD.
REQ-023 HOLD (exactly 2 cycles, covering the I/O interface's output and input registers): hpi_cs = 0, hpi_r = hpi_w = 1, address and data held; on last HOLD cycle of a read, rsp_rdata SHALL load hpi_data_in -> RECOVER.
REQ-024 RECOVER (RECOVERY_CYCLES cycles): hpi_cs = hpi_r = hpi_w = 1 -> IDLE.
REQ-025 rsp_valid SHALL be 1 for exactly the first RECOVER cycle of each transaction.
REQ-026 rsp_rdata SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-027 hpi_r and hpi_w SHALL never be 0 simultaneously, and neither SHALL be 0 while hpi_cs = 1.
REQ-028 hpi_address/hpi_data_out SHALL be stable from SETUP through end of HOLD.
REQ-029 Accept-to-next-req_ready latency SHALL be 1 + STROBE_CYCLES + 2 + RECOVERY_CYCLES cycles (9 at defaults); back-to-back requests SHALL NOT shorten RECOVER.
REQ-030 Phase counter SHALL be 4 bits, load at each state entry, no wrap-around beyond the programmed count.
REQ-031 otg_int SHALL pass through a 2-flop synchroniser to irq; irq_rise = irq && !irq_prev.
REQ-032 req_valid deasserted while busy SHALL have no effect on the in-flight transaction.

Reset
REQ-033 On Reset (any state, any phase): state = IDLE, hpi_cs = hpi_r = hpi_w = 1, hpi_address = 0, hpi_data_out = 0, rsp_valid = 0, rsp_rdata = 0, irq = irq_rise = 0, synchroniser flops = 0, counter = 0, immediately and asynchronously.
REQ-034 Reset asserted mid-transaction SHALL abort it with no rsp_valid; req_ready = 1 on the first Clk edge after Reset deasserts.

Verification
REQ-035 Write addr 2, data 0x1234, defaults -> hpi_cs low 7 cycles, hpi_w low exactly 4, hpi_data_out = 0x1234 throughout, rsp_valid 1 pulse, req_ready back after 9 cycles.
REQ-036 Read addr 3 with hpi_data_in = 0xBEEF from the second STROBE cycle -> hpi_r low 4 cycles, rsp_valid pulse with rsp_rdata = 0xBEEF, hpi_w stays 1.
REQ-037 req_valid held high continuously, alternating write/read -> each accepted only in IDLE, hpi_cs high >= 2 cycles between transactions, strobes never overlap.
REQ-038 Reset asserted during STROBE of a read -> strobes and hpi_cs go to 1 without a Clk edge, no rsp_valid, rsp_rdata = 0.
REQ-039 STROBE_CYCLES = 1, RECOVERY_CYCLES = 15 -> 1-cycle strobe, 4 + 15 = 19-cycle turnaround.
REQ-040 otg_int 0->1 asynchronous -> irq rises 2-3 cycles later, irq_rise single-cycle pulse; otg_int held high -> no further pulses.
